// File: rtl/sp_ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sp_ram_init_ctrl
// Purpose  : Front-end controller for the single-port data SRAM. After reset
//            (or a runtime clear) it writes INIT_VALUE to every word, then
//            forwards bus requests to the RAM with a req/gnt/rvalid handshake.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            clear_i             - restart initialisation (honoured in RUN)
//            init_done_o         - high while RAM is initialised / in RUN
//            req_i/gnt_o         - bus request / same-cycle grant
//            addr_i/we_i/be_i/wdata_i - bus request payload
//            rvalid_o/rdata_o    - response, one cycle after grant
//            ram_*_o / ram_rdata_i - single-port SRAM port
// Revision : 1.0 - initial release
// ============================================================================
module sp_ram_init_ctrl #(
    parameter int                    ADDR_WIDTH = 15,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_WORDS  = 8192,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    output logic                      init_done_o,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      ram_en_o,
    output logic [ADDR_WIDTH-1:0]     ram_addr_o,
    output logic                      ram_we_o,
    output logic [DATA_WIDTH/8-1:0]   ram_be_o,
    output logic [DATA_WIDTH-1:0]     ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

    // Word counter width; a single-word RAM still needs a 1-bit counter.
    localparam int c_CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(NUM_WORDS - 1);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_next_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic               r_rvalid;
    logic               w_gnt;

    // ------------------------------------------------------------------------
    // State, word counter and response-valid registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= w_next_cnt;
            // Every grant (read or write) owes exactly one response next cycle.
            r_rvalid <= w_gnt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and RAM-port steering
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_gnt        = 1'b0;
        ram_en_o     = 1'b0;
        ram_addr_o   = addr_i;
        ram_we_o     = 1'b0;
        ram_be_o     = be_i;
        ram_wdata_o  = wdata_i;

        case (r_state)
            S_INIT: begin
                // Own the RAM port completely: one full-word write per cycle.
                ram_en_o                  = 1'b1;
                ram_we_o                  = 1'b1;
                ram_be_o                  = '1;
                ram_wdata_o               = INIT_VALUE;
                ram_addr_o                = '0;
                ram_addr_o[c_CNT_W+1:0]   = {r_cnt, 2'b00};
                if (r_cnt == c_LAST_WORD) begin
                    w_next_cnt   = '0;
                    w_next_state = S_RUN;
                end else begin
                    w_next_cnt   = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                // A clear takes priority over a same-cycle request.
                w_gnt    = req_i & ~clear_i;
                ram_en_o = w_gnt;
                ram_we_o = we_i & w_gnt;
                if (clear_i) begin
                    w_next_state = S_INIT;
                    w_next_cnt   = '0;
                end
            end
            default: begin
                w_next_state = S_INIT;
                w_next_cnt   = '0;
            end
        endcase
    end

    assign gnt_o       = w_gnt;
    assign init_done_o = (r_state == S_RUN);
    assign rvalid_o    = r_rvalid;
    // The SRAM output is already registered, so read data lines up with rvalid.
    assign rdata_o     = ram_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_init_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_ram_init_ctrl
// Purpose  : Self-checking bench for sp_ram_init_ctrl with a behavioural
//            single-port SRAM and a spec-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_ram_init_ctrl;

    localparam int          c_AW   = 6;
    localparam int          c_DW   = 32;
    localparam int          c_NW   = 16;
    localparam logic [31:0] c_INIT = 32'h0;

    logic            clk;
    logic            rst;
    logic            clear;
    logic            init_done;
    logic            req;
    logic            gnt;
    logic [c_AW-1:0] addr;
    logic            we;
    logic [3:0]      be;
    logic [c_DW-1:0] wdata;
    logic            rvalid;
    logic [c_DW-1:0] rdata;
    logic            ram_en;
    logic [c_AW-1:0] ram_addr;
    logic            ram_we;
    logic [3:0]      ram_be;
    logic [c_DW-1:0] ram_wdata;
    logic [c_DW-1:0] ram_rdata;

    int checks = 0;
    int errors = 0;

    sp_ram_init_ctrl #(
        .ADDR_WIDTH (c_AW),
        .DATA_WIDTH (c_DW),
        .NUM_WORDS  (c_NW),
        .INIT_VALUE (c_INIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (clear),
        .init_done_o (init_done),
        .req_i       (req),
        .gnt_o       (gnt),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_en_o    (ram_en),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_be_o    (ram_be),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port SRAM with registered read data.
    logic [c_DW-1:0] ram_mem [c_NW];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) ram_mem[ram_addr[5:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= ram_mem[ram_addr[5:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: INIT phase writes words 0..NW-1 one per cycle, then RUN
    // grants req & ~clear; every grant yields a response one cycle later.
    // ------------------------------------------------------------------------
    bit              m_known = 1'b0;
    bit              m_init;
    int              m_idx;
    bit              m_rvalid;
    bit              m_rd;
    logic [31:0]     m_exp_rdata;
    logic [31:0]     g_mem [c_NW];

    always @(negedge clk) begin : p_model
        bit eg;
        eg = m_known && !m_init && req && !clear;
        if (m_known) begin
            chk("gnt", 64'(gnt), 64'(eg));
            chk("init_done", 64'(init_done), 64'(!m_init));
            chk("rvalid", 64'(rvalid), 64'(m_rvalid));
            if (m_rvalid && m_rd) chk("rdata", 64'(rdata), 64'(m_exp_rdata));
            chk("ram_en", 64'(ram_en), 64'(m_init || eg));
            if (m_init) begin
                chk("init_addr", 64'(ram_addr), 64'(m_idx * 4));
                chk("init_we", 64'(ram_we), 64'd1);
                chk("init_be", 64'(ram_be), 64'hF);
                chk("init_wdata", 64'(ram_wdata), 64'(c_INIT));
            end else if (eg) begin
                chk("run_addr", 64'(ram_addr), 64'(addr));
                chk("run_we", 64'(ram_we), 64'(we));
                if (we) begin
                    chk("run_be", 64'(ram_be), 64'(be));
                    chk("run_wdata", 64'(ram_wdata), 64'(wdata));
                end
            end else begin
                chk("idle_we", 64'(ram_we), 64'd0);
            end
        end
        // Advance the model with this cycle's inputs.
        if (rst) begin
            m_known  = 1'b1;
            m_init   = 1'b1;
            m_idx    = 0;
            m_rvalid = 1'b0;
        end else if (m_known) begin
            m_rvalid = eg;
            if (eg) begin
                m_rd = !we;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (be[b]) g_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
                end else begin
                    m_exp_rdata = g_mem[addr[5:2]];
                end
            end
            if (m_init) begin
                g_mem[m_idx] = c_INIT;
                if (m_idx == c_NW - 1) begin
                    m_init = 1'b0;
                    m_idx  = 0;
                end else begin
                    m_idx = m_idx + 1;
                end
            end else if (clear) begin
                m_init = 1'b1;
                m_idx  = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walk a full 16-cycle INIT starting in the current cycle; ends in the
    // first RUN cycle, after its falling edge.
    task automatic init_walk();
        for (int i = 0; i < c_NW; i++) begin
            @(negedge clk);
            chk("walk_addr", 64'(ram_addr), 64'(i * 4));
            chk("walk_gnt", 64'(gnt), 64'd0);
            chk("walk_done", 64'(init_done), 64'd0);
            step();
        end
        @(negedge clk);
        chk("walk_done_after16", 64'(init_done), 64'd1);
    endtask

    initial begin : p_stim
        rst = 1'b1; clear = 1'b0; req = 1'b1; we = 1'b0;
        addr = 6'h24; be = 4'hF; wdata = '0;

        // 1: reset, INIT with request held, then read 0x24 granted
        step();
        rst = 1'b0;
        init_walk();
        chk("t1_gnt", 64'(gnt), 64'd1);
        step();
        req = 1'b0;
        @(negedge clk);
        chk("t2_rvalid", 64'(rvalid), 64'd1);
        chk("t2_rdata", 64'(rdata), 64'(c_INIT));

        // 3: partial write then read back
        step();
        req = 1'b1; we = 1'b1; addr = 6'h08; be = 4'b0011; wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("t3_wr_gnt", 64'(gnt), 64'd1);
        step();
        we = 1'b0; be = 4'hF;
        @(negedge clk);
        chk("t3_rvalid_wr", 64'(rvalid), 64'd1);
        step();
        req = 1'b0;
        @(negedge clk);
        chk("t3_rvalid_rd", 64'(rvalid), 64'd1);
        chk("t3_rdata", 64'(rdata), 64'h0000BEEF);

        // 4: read granted, clear next cycle with request still up
        step();
        req = 1'b1; we = 1'b0; addr = 6'h08;
        step();
        clear = 1'b1;
        @(negedge clk);
        chk("t4_rvalid", 64'(rvalid), 64'd1);
        chk("t4_gnt", 64'(gnt), 64'd0);
        chk("t4_rdata", 64'(rdata), 64'h0000BEEF);
        step();
        clear = 1'b0;
        init_walk();
        step();
        req = 1'b0;
        @(negedge clk);
        chk("t4_cleared_rdata", 64'(rdata), 64'(c_INIT));

        // 5: reset in the middle of INIT at word 9
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (9) step();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_addr_cnt9", 64'(ram_addr), 64'h24);
        step();
        rst = 1'b0;
        init_walk();

        // 6: reset the cycle after a grant drops the response
        step();
        req = 1'b1; we = 1'b0; addr = 6'h24;
        @(negedge clk);
        chk("t6_gnt", 64'(gnt), 64'd1);
        step();
        req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rvalid", 64'(rvalid), 64'd0);
        chk("t6_init_done", 64'(init_done), 64'd0);
        chk("t6_ram_addr", 64'(ram_addr), 64'd0);

        // Randomised traffic, with occasional clears and resets
        for (int n = 0; n < 3000; n++) begin
            step();
            req   = ($urandom_range(0, 3) != 0);
            we    = $urandom_range(0, 1) == 1;
            addr  = 6'($urandom);
            be    = 4'($urandom);
            wdata = $urandom;
            clear = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 399) == 0);
        end
        step();
        req = 1'b0; clear = 1'b0; rst = 1'b0;
        repeat (4) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
